fetch_bpred: RTL and testbench

- Front-end fetch PC generator with a dynamic conditional-branch predictor.
- Drives the instruction-memory address and issues instruction, PC+4 and prediction bit (if_pr_taken) to decode; the prediction travels down the pipe to the control-transfer unit.
- Consumes that unit's redirect (force_rdr/next_pc) and resolved-branch updates, closing the loop the execute stage opens.

---
 rtl/alpha_fetch_pkg.sv | 19 +
 rtl/bpred_bht.sv | 57 +++++
 rtl/fetch_bpred.sv | 133 +++++++++++++
 tb/tb_fetch_bpred.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alpha_fetch_pkg.sv
// Shared types and constants for the fetch PC generator and its branch history table.
package alpha_fetch_pkg;

   localparam logic [5:0] OPC_BCOND_LO = 6'h38;
   localparam logic [5:0] OPC_BCOND_HI = 6'h3F;

   typedef logic [1:0] bht_ctr_t;

   localparam bht_ctr_t CTR_WNT = 2'b01;
   localparam bht_ctr_t CTR_ST  = 2'b11;

   typedef enum logic {FS_INIT, FS_RUN} fetch_state_t;

   function automatic bht_ctr_t ctr_step(input bht_ctr_t ctr, input logic taken);
      if (taken) return (ctr == CTR_ST) ? ctr : ctr + 2'd1;
      else       return (ctr == 2'b00)  ? ctr : ctr - 2'd1;
   endfunction

endpackage

// File: rtl/bpred_bht.sv
// Table of 2-bit saturating counters: reset-time sweep to weakly-not-taken,
// one write port shared by sweep and resolved-branch updates, async read port.
module bpred_bht
   import alpha_fetch_pkg::*;
#(
   parameter int IDX_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sweep_en,
   output logic             sweep_last,
   input  logic [IDX_W-1:0] rd_idx,
   output bht_ctr_t         rd_ctr,
   input  logic             upd_valid,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken
);

   localparam int DEPTH = 1 << IDX_W;

   bht_ctr_t         mem [DEPTH];
   logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;
   logic             we;
   logic [IDX_W-1:0] waddr;
   bht_ctr_t         wdata;
   bht_ctr_t         upd_old;

   assign rd_ctr     = mem[rd_idx];
   assign upd_old    = mem[upd_idx];
   assign sweep_last = sweep_en && (sweep_idx_q == {IDX_W{1'b1}});

   always_comb begin
      sweep_idx_d = sweep_idx_q;
      we          = 1'b0;
      waddr       = upd_idx;
      wdata       = ctr_step(upd_old, upd_taken);
      if (sweep_en) begin
         we          = 1'b1;
         waddr       = sweep_idx_q;
         wdata       = CTR_WNT;
         sweep_idx_d = sweep_idx_q + IDX_W'(1);
      end else if (upd_valid) begin
         we = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) sweep_idx_q <= '0;
      else       sweep_idx_q <= sweep_idx_d;
   end

   // No reset on the array so it maps onto plain RAM; the sweep supplies initial contents.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

endmodule

// File: rtl/fetch_bpred.sv
// Fetch PC generator with conditional-branch prediction feeding decode.
// Define FETCH_BPRED_BTFN_EN for static backward-taken/forward-not-taken prediction (no table).
module fetch_bpred
   import alpha_fetch_pkg::*;
#(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter int          BHT_IDX_W = 8
) (
   input  logic        clk,
   input  logic        reset,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        rdr_valid,
   input  logic [63:0] rdr_pc,
   input  logic        upd_valid,
   input  logic [63:0] upd_pc,
   input  logic        upd_taken,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [63:0] if_pc_plus_4,
   output logic        if_pr_taken
);

`ifdef FETCH_BPRED_BTFN_EN
   localparam fetch_state_t ST_RESET = FS_RUN;
`else
   localparam fetch_state_t ST_RESET = FS_INIT;
`endif

   fetch_state_t state_q, state_d;
   logic [63:0]  pc_q, pc_d;
   logic         if_valid_q, if_valid_d;
   logic [31:0]  if_instr_q, if_instr_d;
   logic [63:0]  if_pc_plus_4_q, if_pc_plus_4_d;
   logic         if_pr_taken_q, if_pr_taken_d;

   logic [5:0]   opc;
   logic         is_cond;
   logic         pred;
   logic         sweep_last;
   logic [63:0]  disp;
   logic [63:0]  pc_plus_4;
   logic [63:0]  br_target;
   logic [63:0]  rdr_pc_al;
   logic         unused_bits;

   assign opc       = imem_rdata[31:26];
   assign is_cond   = ({1'b0, opc} >= {1'b0, OPC_BCOND_LO}) && ({1'b0, opc} <= {1'b0, OPC_BCOND_HI});
   assign disp      = {{41{imem_rdata[20]}}, imem_rdata[20:0], 2'b00};
   assign pc_plus_4 = pc_q + 64'd4;
   assign br_target = pc_plus_4 + disp;
   assign rdr_pc_al = {rdr_pc[63:2], 2'b00};

`ifdef FETCH_BPRED_BTFN_EN
   assign pred        = is_cond & imem_rdata[20];
   assign sweep_last  = 1'b1;
   assign unused_bits = ^{rdr_pc[1:0], imem_rdata[25:21], upd_valid, upd_pc, upd_taken};
`else
   bht_ctr_t rd_ctr;

   // Updates only count once the sweep has finished; during INIT they are dropped.
   bpred_bht #(.IDX_W(BHT_IDX_W)) u_bht (
      .clk        (clk),
      .reset      (reset),
      .sweep_en   (state_q == FS_INIT),
      .sweep_last (sweep_last),
      .rd_idx     (pc_q[BHT_IDX_W+1:2]),
      .rd_ctr     (rd_ctr),
      .upd_valid  (upd_valid && (state_q == FS_RUN)),
      .upd_idx    (upd_pc[BHT_IDX_W+1:2]),
      .upd_taken  (upd_taken)
   );

   assign pred        = is_cond & rd_ctr[1];
   assign unused_bits = ^{rdr_pc[1:0], imem_rdata[25:21], upd_pc[63:BHT_IDX_W+2], upd_pc[1:0], rd_ctr[0]};
`endif

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      if_valid_d     = if_valid_q;
      if_instr_d     = if_instr_q;
      if_pc_plus_4_d = if_pc_plus_4_q;
      if_pr_taken_d  = if_pr_taken_q;
      case (state_q)
         FS_INIT: begin
            if_valid_d = 1'b0;
            if (rdr_valid)  pc_d    = rdr_pc_al;
            if (sweep_last) state_d = FS_RUN;
         end
         FS_RUN: begin
            // A redirect wins over stall so the wrong-path slot is always squashed.
            if (rdr_valid) begin
               pc_d       = rdr_pc_al;
               if_valid_d = 1'b0;
            end else if (!stall) begin
               pc_d           = pred ? br_target : pc_plus_4;
               if_valid_d     = 1'b1;
               if_instr_d     = imem_rdata;
               if_pc_plus_4_d = pc_plus_4;
               if_pr_taken_d  = pred;
            end
         end
         default: state_d = ST_RESET;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_RESET;
         pc_q           <= RESET_PC;
         if_valid_q     <= 1'b0;
         if_instr_q     <= '0;
         if_pc_plus_4_q <= '0;
         if_pr_taken_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         if_valid_q     <= if_valid_d;
         if_instr_q     <= if_instr_d;
         if_pc_plus_4_q <= if_pc_plus_4_d;
         if_pr_taken_q  <= if_pr_taken_d;
      end
   end

   assign imem_addr    = pc_q;
   assign if_valid     = if_valid_q;
   assign if_instr     = if_instr_q;
   assign if_pc_plus_4 = if_pc_plus_4_q;
   assign if_pr_taken  = if_pr_taken_q;

endmodule

// File: tb/tb_fetch_bpred.sv
// Directed scoreboard bench for fetch_bpred (default dynamic-predictor build, BHT_IDX_W=8).
module tb_fetch_bpred;

   localparam logic [31:0] I_BEQ   = {6'h39, 5'd0, 21'h000010};
   localparam logic [31:0] I_BGTB  = {6'h3F, 5'd1, 21'h1FFFFF};
   localparam logic [31:0] I_NCOND = {6'h37, 5'd2, 21'h000008};
   localparam logic [31:0] I_MISC  = 32'h12345678;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        stall, rdr_valid, upd_valid, upd_taken;
   logic [63:0] rdr_pc, upd_pc;
   logic        if_valid, if_pr_taken;
   logic [31:0] if_instr;
   logic [63:0] if_pc_plus_4;

   typedef struct {
      logic        valid;
      logic [31:0] instr;
      logic [63:0] pc4;
      logic        pr;
      logic [63:0] addr;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   logic [63:0] m_pc;
   logic        m_valid;
   logic [31:0] m_instr;
   logic [63:0] m_pc4;
   logic        m_pr;

   fetch_bpred #(.RESET_PC(64'h0), .BHT_IDX_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .stall        (stall),
      .rdr_valid    (rdr_valid),
      .rdr_pc       (rdr_pc),
      .upd_valid    (upd_valid),
      .upd_pc       (upd_pc),
      .upd_taken    (upd_taken),
      .if_valid     (if_valid),
      .if_instr     (if_instr),
      .if_pc_plus_4 (if_pc_plus_4),
      .if_pr_taken  (if_pr_taken)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memRead(input logic [63:0] a);
      case (a)
         64'h40:   return I_BEQ;
         64'h100:  return I_BGTB;
         64'h200:  return I_NCOND;
         64'h2000: return I_MISC;
         default:  return 32'h0;
      endcase
   endfunction

   assign imem_rdata = memRead(imem_addr);

   function automatic logic [63:0] dispOf(input logic [31:0] ins);
      return {{41{ins[20]}}, ins[20:0], 2'b00};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Drives one cycle of inputs and pushes what the outputs must be after the edge.
   task automatic applyStimulus(input logic rv, input logic [63:0] rp, input logic st,
                                input logic uv, input logic [63:0] up, input logic ut,
                                input logic exp_pr);
      exp_t e;
      logic [31:0] ins;
      rdr_valid = rv; rdr_pc = rp; stall = st;
      upd_valid = uv; upd_pc = up; upd_taken = ut;
      if (rv) begin
         m_pc    = {rp[63:2], 2'b00};
         m_valid = 1'b0;
      end else if (!st) begin
         ins     = memRead(m_pc);
         m_valid = 1'b1;
         m_instr = ins;
         m_pc4   = m_pc + 64'd4;
         m_pr    = exp_pr;
         m_pc    = exp_pr ? (m_pc + 64'd4 + dispOf(ins)) : (m_pc + 64'd4);
      end
      e.valid = m_valid; e.instr = m_instr; e.pc4 = m_pc4; e.pr = m_pr; e.addr = m_pc;
      sb.push_back(e);
   endtask

   task automatic checkOutput(input string lbl);
      exp_t e;
      if (sb.size() == 0) begin
         chk({lbl, ".scoreboard_empty"}, 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         chk({lbl, ".valid"}, {63'd0, if_valid}, {63'd0, e.valid});
         chk({lbl, ".instr"}, {32'd0, if_instr}, {32'd0, e.instr});
         chk({lbl, ".pc4"},   if_pc_plus_4, e.pc4);
         chk({lbl, ".pr"},    {63'd0, if_pr_taken}, {63'd0, e.pr});
         chk({lbl, ".addr"},  imem_addr, e.addr);
      end
   endtask

   task automatic step(input string lbl, input logic rv, input logic [63:0] rp, input logic st,
                       input logic uv, input logic [63:0] up, input logic ut, input logic exp_pr);
      applyStimulus(rv, rp, st, uv, up, ut, exp_pr);
      tick();
      checkOutput(lbl);
   endtask

   task automatic fetch(input string lbl, input logic exp_pr);
      step(lbl, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, exp_pr);
   endtask

   task automatic fetchUpd(input string lbl, input logic [63:0] up, input logic ut, input logic exp_pr);
      step(lbl, 1'b0, 64'h0, 1'b0, 1'b1, up, ut, exp_pr);
   endtask

   task automatic redirect(input string lbl, input logic [63:0] rp, input logic st);
      step(lbl, 1'b1, rp, st, 1'b0, 64'h0, 1'b0, 1'b0);
   endtask

   task automatic resetModel();
      m_pc = 64'h0; m_valid = 1'b0; m_instr = '0; m_pc4 = '0; m_pr = 1'b0;
   endtask

   task automatic checkResetState(input string lbl);
      chk({lbl, ".addr"},  imem_addr, 64'h0);
      chk({lbl, ".valid"}, {63'd0, if_valid}, 64'd0);
      chk({lbl, ".instr"}, {32'd0, if_instr}, 64'd0);
      chk({lbl, ".pc4"},   if_pc_plus_4, 64'h0);
      chk({lbl, ".pr"},    {63'd0, if_pr_taken}, 64'd0);
   endtask

   // 256 sweep cycles; optionally a redirect mid-sweep and taken updates that must be ignored.
   task automatic runInit(input logic mid);
      for (int i = 0; i < 256; i++) begin
         rdr_valid = mid && (i == 10);
         rdr_pc    = 64'h43;
         upd_valid = mid;
         upd_pc    = 64'h40;
         upd_taken = 1'b1;
         stall     = 1'b0;
         tick();
         if (mid && (i == 10)) m_pc = 64'h40;
         chk("init.addr",  imem_addr, m_pc);
         chk("init.valid", {63'd0, if_valid}, 64'd0);
      end
      rdr_valid = 1'b0; upd_valid = 1'b0; upd_taken = 1'b0;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; rdr_valid = 1'b0; rdr_pc = '0;
      upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
      resetModel();
      #12;
      checkResetState("reset");
      reset = 1'b0;
      runInit(1'b0);
      fetch("first_fetch", 1'b0);

      redirect("rdr_40", 64'h40, 1'b0);
      fetch("beq_untrained", 1'b0);
      fetchUpd("train_t1", 64'h40, 1'b1, 1'b0);
      fetchUpd("train_t2", 64'h40, 1'b1, 1'b0);
      redirect("rdr_40b", 64'h40, 1'b0);
      fetch("beq_trained", 1'b1);
      fetchUpd("train_nt1", 64'h40, 1'b0, 1'b0);
      fetchUpd("train_nt2", 64'h40, 1'b0, 1'b0);
      fetchUpd("train_nt3", 64'h40, 1'b0, 1'b0);
      redirect("rdr_40c", 64'h40, 1'b0);
      fetch("beq_after_3nt", 1'b0);
      fetchUpd("train_nt4_sat", 64'h40, 1'b0, 1'b0);
      fetchUpd("train_t_from0", 64'h40, 1'b1, 1'b0);
      redirect("rdr_40d", 64'h40, 1'b0);
      fetchUpd("beq_rbw_same_cycle", 64'h40, 1'b1, 1'b0);
      redirect("rdr_40e", 64'h40, 1'b0);
      fetch("beq_after_rbw", 1'b1);

      fetchUpd("train_100_t1", 64'h100, 1'b1, 1'b0);
      fetchUpd("train_100_t2", 64'h100, 1'b1, 1'b0);
      redirect("rdr_100", 64'h100, 1'b0);
      fetch("bgt_back_loop1", 1'b1);
      fetchUpd("bgt_back_loop2", 64'h200, 1'b1, 1'b1);
      fetchUpd("bgt_back_loop3", 64'h200, 1'b1, 1'b1);
      redirect("rdr_200", 64'h200, 1'b0);
      fetch("op37_not_cond", 1'b0);

      redirect("rdr_stall", 64'h2003, 1'b1);
      step("stall_hold_squashed", 1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
      fetch("resume_2000", 1'b0);
      step("stall_hold_valid", 1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
      fetch("resume_2004", 1'b0);

      #2 reset = 1'b1;
      #1;
      resetModel();
      checkResetState("mid_reset");
      #2 reset = 1'b0;
      runInit(1'b1);
      fetch("beq_after_resweep", 1'b0);
      fetch("seq_after_resweep", 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
